// File: rtl/draw_sequencer.sv
// Frame-level initiator for the rectangle drawer: on each frame tick, erase
// last frame's rectangles from stored history, then draw all live objects.
module draw_sequencer #(
    parameter int unsigned NUM_OBJ  = 8,
    parameter int unsigned IDX_W    = 3,
    parameter logic [2:0]  BG_COLOR = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    output logic [IDX_W-1:0] obj_idx,
    input  logic             obj_active,
    input  logic [7:0]       obj_x,
    input  logic [6:0]       obj_y,
    input  logic [4:0]       obj_w,
    input  logic [4:0]       obj_h,
    input  logic [2:0]       obj_c,
    output logic [7:0]       drw_x,
    output logic [6:0]       drw_y,
    output logic [4:0]       drw_w,
    output logic [4:0]       drw_h,
    output logic [2:0]       drw_c,
    output logic             drw_go,
    input  logic             drw_done,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_E_SCAN,
        S_E_WAIT,
        S_E_GAP,
        S_D_SCAN,
        S_D_WAIT,
        S_D_GAP,
        S_FINISH
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_drw_x;
    logic [6:0]         r_drw_y;
    logic [4:0]         r_drw_w;
    logic [4:0]         r_drw_h;
    logic [2:0]         r_drw_c;
    logic               r_drw_go;
    logic               r_busy;
    logic               r_frame_done;
    logic               r_overrun;

    // Per-slot history of what was drawn last frame (erase source)
    logic [7:0]         r_prev_x [NUM_OBJ];
    logic [6:0]         r_prev_y [NUM_OBJ];
    logic [4:0]         r_prev_w [NUM_OBJ];
    logic [4:0]         r_prev_h [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_prev_valid;

    logic               w_last;
    logic               w_draw_ok;
    logic               w_in_draw;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_draw_ok = obj_active && (obj_w != '0) && (obj_h != '0);
    assign w_in_draw = (r_state == S_D_SCAN) || (r_state == S_D_WAIT) ||
                       (r_state == S_D_GAP);

    assign obj_idx    = w_in_draw ? r_idx : '0;
    assign drw_x      = r_drw_x;
    assign drw_y      = r_drw_y;
    assign drw_w      = r_drw_w;
    assign drw_h      = r_drw_h;
    assign drw_c      = r_drw_c;
    assign drw_go     = r_drw_go;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

    // Sequencer FSM: erase pass, draw pass, history update and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_drw_x      <= '0;
            r_drw_y      <= '0;
            r_drw_w      <= '0;
            r_drw_h      <= '0;
            r_drw_c      <= '0;
            r_drw_go     <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_prev_valid <= '0;
            for (int unsigned k = 0; k < NUM_OBJ; k++) begin
                r_prev_x[k] <= '0;
                r_prev_y[k] <= '0;
                r_prev_w[k] <= '0;
                r_prev_h[k] <= '0;
            end
        end else begin
            if (frame_tick && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (frame_tick) begin
                        r_state <= S_E_SCAN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_E_SCAN: begin
                    if (r_prev_valid[r_idx]) begin
                        r_drw_x  <= r_prev_x[r_idx];
                        r_drw_y  <= r_prev_y[r_idx];
                        r_drw_w  <= r_prev_w[r_idx];
                        r_drw_h  <= r_prev_h[r_idx];
                        r_drw_c  <= BG_COLOR;
                        r_drw_go <= 1'b1;
                        r_state  <= S_E_WAIT;
                    end else if (w_last) begin
                        r_state <= S_D_SCAN;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_E_WAIT: begin
                    if (drw_done) begin
                        r_drw_go <= 1'b0;
                        r_state  <= S_E_GAP;
                    end
                end
                S_E_GAP: begin
                    if (w_last) begin
                        r_state <= S_D_SCAN;
                        r_idx   <= '0;
                    end else begin
                        r_state <= S_E_SCAN;
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                S_D_SCAN: begin
                    if (w_draw_ok) begin
                        r_drw_x             <= obj_x;
                        r_drw_y             <= obj_y;
                        r_drw_w             <= obj_w;
                        r_drw_h             <= obj_h;
                        r_drw_c             <= obj_c;
                        r_drw_go            <= 1'b1;
                        r_prev_x[r_idx]     <= obj_x;
                        r_prev_y[r_idx]     <= obj_y;
                        r_prev_w[r_idx]     <= obj_w;
                        r_prev_h[r_idx]     <= obj_h;
                        r_prev_valid[r_idx] <= 1'b1;
                        r_state             <= S_D_WAIT;
                    end else begin
                        r_prev_valid[r_idx] <= 1'b0;
                        if (w_last) begin
                            r_state      <= S_FINISH;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                S_D_WAIT: begin
                    if (drw_done) begin
                        r_drw_go <= 1'b0;
                        r_state  <= S_D_GAP;
                    end
                end
                S_D_GAP: begin
                    if (w_last) begin
                        r_state      <= S_FINISH;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state <= S_D_SCAN;
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                S_FINISH: begin
                    r_frame_done <= 1'b0;
                    r_idx        <= '0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
